// File: rtl/prog_seq_gen.sv
// prog_seq_gen: programmable serial pattern source; emits pat_r LSB-first on Y.
// Latency: start edge -> first valid bit is 1 cycle; outputs depend on registers only.
// Backpressure: en=0 in RUN stalls idx, Y and valid; abort returns to ARMED.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load/pat_i/len_i/loop_i  capture pattern, length-1 (clamped to PAT_W-1), loop mode
//   start               begin emission from ARMED
//   en                  consumer accepts Y; advances idx
//   abort               leave RUN for ARMED with no done/wrap pulse
//   Y/valid/idx         current bit, its qualifier and its index
//   st/busy/done/wrap   state code, RUN flag, one-shot end pulse, loop wrap pulse
module prog_seq_gen #(
   parameter int PAT_W = 16,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [PAT_W-1:0] pat_i,
   input  logic [IDX_W-1:0] len_i,
   input  logic             loop_i,
   input  logic             start,
   input  logic             en,
   input  logic             abort,
   output logic             Y,
   output logic             valid,
   output logic [IDX_W-1:0] idx,
   output logic [1:0]       st,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ARMED = 2'b01,
      S_RUN   = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   localparam logic [IDX_W-1:0] LEN_MAX = IDX_W'(PAT_W - 1);

   state_t           state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [IDX_W-1:0] len_q, len_d;
   logic             loop_q, loop_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             wrap_q, wrap_d;

   logic [IDX_W-1:0] len_clamped;
   logic [PAT_W-1:0] pat_sh;

   // Lengths beyond the pattern register are clamped to its last bit.
   assign len_clamped = (len_i > LEN_MAX) ? LEN_MAX : len_i;

   // Shift instead of a variable bit-select so IDX_W may exceed clog2(PAT_W).
   assign pat_sh = pat_q >> idx_q;

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      loop_d  = loop_q;
      idx_d   = idx_q;
      wrap_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (load) begin
               pat_d   = pat_i;
               len_d   = len_clamped;
               loop_d  = loop_i;
               state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            // load wins over start when both are high
            if (load) begin
               pat_d  = pat_i;
               len_d  = len_clamped;
               loop_d = loop_i;
            end else if (start) begin
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // abort has priority over en and suppresses done/wrap
            if (abort) begin
               idx_d   = '0;
               state_d = S_ARMED;
            end else if (en) begin
               if (idx_q == len_q) begin
                  idx_d = '0;
                  if (loop_q) begin
                     wrap_d = 1'b1;
                  end else begin
                     state_d = S_DONE;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_ARMED;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pat_q   <= '0;
         len_q   <= '0;
         loop_q  <= 1'b0;
         idx_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         loop_q  <= loop_d;
         idx_q   <= idx_d;
         wrap_q  <= wrap_d;
      end
   end

   assign busy  = (state_q == S_RUN);
   assign valid = busy;
   assign Y     = busy & pat_sh[0];
   assign idx   = idx_q;
   assign st    = state_q;
   assign done  = (state_q == S_DONE);
   assign wrap  = wrap_q;

endmodule
